ctrl_fsm: RTL and testbench

//  Multi-cycle control unit for the simplified RV32I core. Replaces the single-cycle decoder.

---
 rtl/ctrl_fsm.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB with req/gnt memory handshakes,
// traps on illegal opcodes or memory stalls, and counts retired instructions.
package ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } aluop_sel_t;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

endpackage

// Handshake: a request (imem_req/dmem_req) stays high every cycle until the matching gnt is seen
// high in the same cycle; gnt without a request is ignored. instr and load data are valid with gnt.
module ctrl_fsm
    import ctrl_fsm_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 alu_zero,
    input  logic                 imem_gnt,
    input  logic                 dmem_gnt,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 mem_wen,
    output logic                 ir_wen,
    output logic                 pc_wen,
    output logic                 pc_src,
    output aluop_sel_t           alu_sel,
    output logic                 alu_src,
    output logic [2:0]           imm_src,
    output logic                 reg_wen,
    output logic [1:0]           reg_wdata_src,
    output logic                 halted,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] instret
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT_CYC - 1);

    state_t               state;
    state_t               state_nx;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [WAIT_W-1:0]    wait_nx;
    logic [1:0]           cause_q;
    logic [1:0]           cause_nx;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 retire;
    logic                 fetch_take;

    // Only the fields the control path needs are kept from the fetched word.
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7_alt;

    logic                 unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic       legal;
    aluop_sel_t dec_alu;
    logic       dec_alu_src;
    logic [2:0] dec_imm;
    logic [1:0] dec_wsrc;

    function automatic aluop_sel_t alu_from_funct(input logic [2:0] f3, input logic alt,
                                                  input logic reg_form);
        aluop_sel_t op;
        case (f3)
            3'd0:    op = (alt && reg_form) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);

    always_comb begin
        dec_alu     = ALU_ADD;
        dec_alu_src = 1'b0;
        dec_imm     = IMM_I;
        dec_wsrc    = WB_ALU;
        legal       = 1'b1;
        case (opcode)
            OPC_OP:     dec_alu = alu_from_funct(funct3, funct7_alt, 1'b1);
            OPC_OP_IMM: begin
                dec_alu     = alu_from_funct(funct3, funct7_alt, 1'b0);
                dec_alu_src = 1'b1;
            end
            OPC_LOAD: begin
                dec_alu_src = 1'b1;
                dec_wsrc    = WB_MEM;
            end
            OPC_STORE: begin
                dec_alu_src = 1'b1;
                dec_imm     = IMM_S;
            end
            OPC_BRANCH: begin
                dec_alu = ALU_SUB;
                dec_imm = IMM_B;
                legal   = (funct3[2:1] == 2'b00);
            end
            OPC_JAL: begin
                dec_imm  = IMM_J;
                dec_wsrc = WB_PC4;
            end
            OPC_LUI: begin
                dec_imm  = IMM_U;
                dec_wsrc = WB_IMM;
            end
            default:    legal = 1'b0;
        endcase
    end

    assign fetch_take = (state == S_FETCH) && imem_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            wait_cnt   <= '0;
            cause_q    <= CAUSE_NONE;
            cnt_q      <= '0;
            opcode     <= '0;
            funct3     <= '0;
            funct7_alt <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            cause_q  <= cause_nx;
            if (retire) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (fetch_take) begin
                opcode     <= instr[6:0];
                funct3     <= instr[14:12];
                funct7_alt <= instr[30];
            end
        end
    end

    always_comb begin
        state_nx      = state;
        wait_nx       = '0;
        cause_nx      = cause_q;
        retire        = 1'b0;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        mem_wen       = 1'b0;
        ir_wen        = 1'b0;
        pc_wen        = 1'b0;
        pc_src        = 1'b0;
        alu_sel       = ALU_ADD;
        alu_src       = 1'b0;
        imm_src       = IMM_I;
        reg_wen       = 1'b0;
        reg_wdata_src = WB_ALU;
        halted        = 1'b0;
        trap_cause    = cause_q;

        // Decoded datapath controls stay stable for the whole life of the instruction.
        if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            alu_sel       = dec_alu;
            alu_src       = dec_alu_src;
            imm_src       = dec_imm;
            reg_wdata_src = dec_wsrc;
        end

        unique case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    ir_wen   = 1'b1;
                    state_nx = S_DECODE;
                end else if (wait_cnt == WAIT_LIM) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_IMEM_TO;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_nx = S_EXEC;
                end else begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_wen   = 1'b1;
                    pc_src   = funct3[0] ? !alu_zero : alu_zero;
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end else if (is_load || is_store) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                mem_wen  = is_store;
                if (dmem_gnt) begin
                    if (is_store) begin
                        pc_wen   = 1'b1;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end else if (wait_cnt == WAIT_LIM) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_DMEM_TO;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
            end
            S_WB: begin
                reg_wen  = 1'b1;
                pc_wen   = 1'b1;
                pc_src   = is_jal;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_TRAP: begin
                halted = 1'b1;
            end
            default: begin
                state_nx = S_FETCH;
            end
        endcase

        if (rst) begin
            imem_req      = 1'b0;
            dmem_req      = 1'b0;
            mem_wen       = 1'b0;
            ir_wen        = 1'b0;
            pc_wen        = 1'b0;
            pc_src        = 1'b0;
            alu_sel       = ALU_ADD;
            alu_src       = 1'b0;
            imm_src       = IMM_I;
            reg_wen       = 1'b0;
            reg_wdata_src = WB_ALU;
            halted        = 1'b0;
            trap_cause    = CAUSE_NONE;
        end
    end

    assign instret = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: directed scenarios plus random instruction streams
// compared against an instruction-level reference model.
module tb_ctrl_fsm;
    import ctrl_fsm_pkg::*;

    localparam int CW = 4;
    localparam int TO = 16;
    localparam int K_OP = 0, K_OPI = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_LUI = 6, K_ILL = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instr = '0;
    logic          alu_zero = 1'b0;
    logic          imem_gnt = 1'b0;
    logic          dmem_gnt = 1'b0;
    logic          imem_req, dmem_req, mem_wen, ir_wen, pc_wen, pc_src;
    aluop_sel_t    alu_sel;
    logic          alu_src;
    logic [2:0]    imm_src;
    logic          reg_wen;
    logic [1:0]    reg_wdata_src;
    logic          halted;
    logic [1:0]    trap_cause;
    logic [CW-1:0] instret;

    ctrl_fsm #(.CNT_WIDTH(CW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero),
        .imem_gnt(imem_gnt), .dmem_gnt(dmem_gnt),
        .imem_req(imem_req), .dmem_req(dmem_req), .mem_wen(mem_wen), .ir_wen(ir_wen),
        .pc_wen(pc_wen), .pc_src(pc_src), .alu_sel(alu_sel), .alu_src(alu_src),
        .imm_src(imm_src), .reg_wen(reg_wen), .reg_wdata_src(reg_wdata_src),
        .halted(halted), .trap_cause(trap_cause), .instret(instret)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int exp_instret = 0;
    int last_cycles = 0;
    bit tb_halted = 0;
    logic [CW-1:0] exp_q[$];

    // Reference tables indexed by instruction kind / funct3.
    logic [6:0] opc_tab[7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                               7'b1100011, 7'b1101111, 7'b0110111};
    int imm_tab[8]  = '{0, 0, 0, 1, 2, 4, 3, 0};
    int wsrc_tab[8] = '{0, 0, 1, 0, 0, 2, 3, 0};
    aluop_sel_t base_alu[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

    typedef struct {
        int         kind;
        aluop_sel_t alu;
        bit         asrc;
        int         imm;
        int         wsrc;
    } exp_t;

    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        logic [2:0] f3;
        f3 = ins[14:12];
        e.kind = K_ILL;
        for (int k = 0; k < 7; k++) if (ins[6:0] == opc_tab[k]) e.kind = k;
        if (e.kind == K_BR && f3 > 3'd1) e.kind = K_ILL;
        e.alu = ALU_ADD;
        if (e.kind == K_OP || e.kind == K_OPI) begin
            e.alu = base_alu[f3];
            if (ins[30] && f3 == 3'd5) e.alu = ALU_SRA;
            if (ins[30] && f3 == 3'd0 && e.kind == K_OP) e.alu = ALU_SUB;
        end
        if (e.kind == K_BR) e.alu = ALU_SUB;
        e.asrc = (e.kind == K_OPI || e.kind == K_LD || e.kind == K_ST);
        e.imm  = imm_tab[e.kind];
        e.wsrc = wsrc_tab[e.kind];
        return e;
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 6);
        w[6:0] = opc_tab[k];
        if (k == K_BR) w[14:12] = 3'($urandom_range(0, 1));
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1; imem_gnt = 1'b0; dmem_gnt = 1'b0; alu_zero = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({imem_req, dmem_req, mem_wen, ir_wen, pc_wen, pc_src, alu_sel, alu_src, imm_src,
             reg_wen, reg_wdata_src, halted, trap_cause, instret} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: some output nonzero during rst (imem_req=%b halted=%b instret=%0d)",
                     imem_req, halted, instret);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_instret = 0; exp_q.delete(); tb_halted = 0;
        #1;
        n_checks++;
        if ({imem_req, halted, trap_cause, instret} !== {1'b1, 1'b0, 2'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL post_reset: got req=%b halted=%b cause=%0d instret=%0d, expected 1 0 0 0",
                     imem_req, halted, trap_cause, instret);
        end
    endtask

    task automatic retire_check(input string name);
        logic [CW-1:0] want;
        exp_instret = (exp_instret + 1) % (1 << CW);
        exp_q.push_back(CW'(exp_instret));
        @(posedge clk); #1;
        last_cycles++;
        want = exp_q.pop_front();
        n_checks++;
        if (instret !== want || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_retire: got instret=%0d req=%b, expected instret=%0d req=1",
                     name, instret, imem_req, want);
        end
    endtask

    // Drives one instruction from FETCH back to FETCH (or TRAP); starts just after a clock edge in FETCH.
    task automatic run_instr(input logic [31:0] ins, input int igap, input int dgap, input bit az);
        exp_t e;
        bit taken;
        bit st;
        e = model(ins);
        st = (e.kind == K_ST);
        last_cycles = 0;
        imem_gnt = 1'b0;
        for (int k = 0; k < igap && k < TO; k++) begin
            #1;
            n_checks++;
            if ({imem_req, ir_wen, halted} !== 3'b100) begin
                n_fail++;
                $display("FAIL fetch_wait: got req/irw/halt=%b, expected 100", {imem_req, ir_wen, halted});
            end
            @(posedge clk); #1;
        end
        if (igap >= TO) begin
            #1;
            n_checks++;
            if ({halted, trap_cause, imem_req, ir_wen} !== {1'b1, 2'd2, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL imem_timeout: got halt=%b cause=%0d req=%b, expected 1 2 0", halted, trap_cause, imem_req);
            end
            tb_halted = 1;
            return;
        end
        imem_gnt = 1'b1; instr = ins;
        #1;
        n_checks++;
        if ({imem_req, ir_wen} !== 2'b11) begin
            n_fail++;
            $display("FAIL fetch_gnt: got req/irw=%b, expected 11", {imem_req, ir_wen});
        end
        @(posedge clk); #1;
        last_cycles++;
        imem_gnt = 1'b0; instr = $urandom;
        #1;
        n_checks++;
        if ({imem_req, dmem_req, pc_wen, reg_wen, halted} !== 5'b0 ||
            (e.kind != K_OP && e.kind != K_ILL && imm_src !== 3'(e.imm))) begin
            n_fail++;
            $display("FAIL decode: got req=%b dreq=%b pcw=%b rw=%b imm=%0d, expected 0 0 0 0 imm=%0d",
                     imem_req, dmem_req, pc_wen, reg_wen, imm_src, e.imm);
        end
        @(posedge clk); #1;
        last_cycles++;
        if (e.kind == K_ILL) begin
            n_checks++;
            if ({halted, trap_cause, imem_req, pc_wen} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL illegal_trap: got halt=%b cause=%0d req=%b, expected 1 1 0", halted, trap_cause, imem_req);
            end
            tb_halted = 1;
            return;
        end
        alu_zero = az;
        #1;
        n_checks++;
        if (alu_src !== e.asrc || (e.kind <= K_BR && alu_sel !== e.alu)) begin
            n_fail++;
            $display("FAIL exec_alu: got sel=%s src=%b, expected sel=%s src=%b", alu_sel.name(), alu_src, e.alu.name(), e.asrc);
        end
        if (e.kind == K_BR) begin
            taken = (ins[14:12] == 3'd0) ? az : !az;
            n_checks++;
            if ({pc_wen, pc_src, reg_wen, dmem_req} !== {1'b1, taken, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL branch: got pcw=%b pcsrc=%b rw=%b, expected 1 %b 0", pc_wen, pc_src, reg_wen, taken);
            end
            retire_check("branch");
            alu_zero = 1'b0;
            return;
        end
        n_checks++;
        if ({pc_wen, reg_wen, dmem_req} !== 3'b0) begin
            n_fail++;
            $display("FAIL exec_quiet: got pcw=%b rw=%b dreq=%b, expected 000", pc_wen, reg_wen, dmem_req);
        end
        @(posedge clk); #1;
        last_cycles++;
        alu_zero = 1'b0;
        if (e.kind == K_LD || e.kind == K_ST) begin
            for (int k = 0; k < dgap && k < TO; k++) begin
                #1;
                n_checks++;
                if ({dmem_req, mem_wen, pc_wen, reg_wen} !== {1'b1, st, 2'b00} || imm_src !== 3'(e.imm)) begin
                    n_fail++;
                    $display("FAIL mem_wait: got dreq/wen/pcw/rw=%b imm=%0d, expected %b imm=%0d",
                             {dmem_req, mem_wen, pc_wen, reg_wen}, imm_src, {1'b1, st, 2'b00}, e.imm);
                end
                @(posedge clk); #1;
                last_cycles++;
            end
            if (dgap >= TO) begin
                #1;
                n_checks++;
                if ({halted, trap_cause, dmem_req, reg_wen} !== {1'b1, 2'd3, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL dmem_timeout: got halt=%b cause=%0d dreq=%b, expected 1 3 0", halted, trap_cause, dmem_req);
                end
                tb_halted = 1;
                return;
            end
            dmem_gnt = 1'b1;
            #1;
            n_checks++;
            if ({dmem_req, mem_wen, pc_wen, reg_wen} !== {1'b1, st, st, 1'b0}) begin
                n_fail++;
                $display("FAIL mem_gnt: got dreq/wen/pcw/rw=%b, expected %b", {dmem_req, mem_wen, pc_wen, reg_wen}, {1'b1, st, st, 1'b0});
            end
            if (st) begin
                retire_check("store");
                dmem_gnt = 1'b0;
                return;
            end
            @(posedge clk); #1;
            last_cycles++;
            dmem_gnt = 1'b0;
        end
        #1;
        n_checks++;
        if ({reg_wen, pc_wen, pc_src, dmem_req, imem_req} !== {2'b11, (e.kind == K_JAL), 2'b00} ||
            reg_wdata_src !== 2'(e.wsrc) || alu_src !== e.asrc || instret !== CW'(exp_instret)) begin
            n_fail++;
            $display("FAIL wb: got rw=%b pcw=%b pcsrc=%b wsrc=%0d asrc=%b instret=%0d, expected 1 1 %b %0d %b %0d",
                     reg_wen, pc_wen, pc_src, reg_wdata_src, alu_src, instret,
                     (e.kind == K_JAL), e.wsrc, e.asrc, exp_instret);
        end
        retire_check("wb");
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_addi();
        run_instr(32'h0050_0093, 0, 0, 1'b0);
        n_checks++;
        if (last_cycles !== 4 || instret !== 4'd1) begin
            n_fail++;
            $display("FAIL addi_latency: got cycles=%0d instret=%0d, expected 4 1", last_cycles, instret);
        end
    endtask

    task automatic test_alu_decode();
        run_instr(32'h4000_0033, 0, 0, 1'b0);  // sub
        run_instr(32'h4000_5033, 1, 0, 1'b0);  // sra
        run_instr(32'h4000_5013, 0, 0, 1'b0);  // srai
        run_instr(32'h4000_0013, 0, 0, 1'b0);  // addi with bit30 set stays ADD
        run_instr(32'h0000_00b7, 0, 0, 1'b0);  // lui
        run_instr(32'h0000_006f, 2, 0, 1'b0);  // jal
    endtask

    task automatic test_store_stall();
        run_instr(32'h0000_2023, 0, 3, 1'b0);  // sw
        run_instr(32'h0000_2003, 0, 2, 1'b0);  // lw
    endtask

    task automatic test_branch();
        run_instr(32'h0000_0063, 0, 0, 1'b1);  // beq taken
        run_instr(32'h0000_1063, 0, 0, 1'b1);  // bne not taken
        run_instr(32'h0000_1063, 0, 0, 1'b0);  // bne taken
        run_instr(32'h0000_2063, 0, 0, 1'b0);  // funct3=2 branch is illegal
        do_reset();
    endtask

    task automatic test_imem_timeout();
        run_instr(32'h0050_0093, 0, 0, 1'b0);
        run_instr(32'h0050_0093, TO, 0, 1'b0);
        imem_gnt = 1'b1; instr = 32'h0050_0093;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({halted, trap_cause, imem_req, ir_wen, pc_wen, reg_wen} !== {1'b1, 2'd2, 4'b0} || instret !== 4'd1) begin
                n_fail++;
                $display("FAIL trap_hold: got halt=%b cause=%0d req=%b irw=%b instret=%0d, expected 1 2 0 0 1",
                         halted, trap_cause, imem_req, ir_wen, instret);
            end
        end
        do_reset();
    endtask

    task automatic test_dmem_timeout();
        run_instr(32'h0000_2003, 0, TO, 1'b0);
        do_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_instr(rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++)
            run_instr(rand_legal(), $urandom_range(0, 1), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        n_checks++;
        if (instret !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap: got instret=%0d, expected 1", instret);
        end
    endtask

    task automatic test_reset_mid();
        run_instr(32'h0050_0093, 0, 0, 1'b0);
        imem_gnt = 1'b1; instr = 32'h0000_2003;
        @(posedge clk); #1;
        imem_gnt = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; dmem_gnt = 1'b1;
        #1;
        n_checks++;
        if ({dmem_req, reg_wen, pc_wen, instret} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got dreq=%b rw=%b pcw=%b instret=%0d, expected all 0", dmem_req, reg_wen, pc_wen, instret);
        end
        @(posedge clk); #1;
        rst = 1'b0; dmem_gnt = 1'b0; exp_instret = 0; exp_q.delete();
        #1;
        n_checks++;
        if ({imem_req, halted, instret} !== {1'b1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL after_mid_reset: got req=%b halt=%b instret=%0d, expected 1 0 0", imem_req, halted, instret);
        end
        run_instr(32'h0000_2003, 0, 1, 1'b0);
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        test_reset();
        test_addi();
        test_alu_decode();
        test_store_stall();
        test_branch();
        test_imem_timeout();
        test_dmem_timeout();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
